// File: rtl/cpu_ram.sv
// Tiny 4-bit accumulator CPU executing one instruction per clock.
// Instructions are fetched from a 256x8 RAM that can be written while the CPU runs.
module cpu_ram (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic [3:0] led,
    input  logic       write_req,
    input  logic [7:0] w_addr,
    input  logic [7:0] w_data,
    output logic [3:0] pc
);

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_BI = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_IM = 4'b1011,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } opcode_e;

    logic [7:0] mem_q [256];

    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       c_q, c_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] led_q, led_d;

    logic [7:0] instr;
    logic [3:0] opcode;
    logic [3:0] imm;
    logic [4:0] sum_a;
    logic [4:0] sum_b;

    // NOTE: the program memory has no reset; contents must survive a CPU reset.
    always_ff @(posedge clk) begin
        if (write_req) begin
            mem_q[w_addr] <= w_data;
        end
    end

    // The fetch sees the pre-edge contents, so a same-cycle write to the fetched
    // address only affects the next visit to that address.
    assign instr  = mem_q[{4'b0000, pc_q}];
    assign opcode = instr[7:4];
    assign imm    = instr[3:0];
    assign sum_a  = {1'b0, a_q} + {1'b0, imm};
    assign sum_b  = {1'b0, b_q} + {1'b0, imm};

    // NOTE: every next-state signal gets a default first, so no latch is inferred.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = 1'b0;
        led_d = led_q;
        pc_d  = pc_q + 4'd1;
        case (opcode)
            OP_ADD_A: begin
                a_d = sum_a[3:0];
                c_d = sum_a[4];
            end
            OP_ADD_B: begin
                b_d = sum_b[3:0];
                c_d = sum_b[4];
            end
            OP_MOV_AB: a_d   = b_q;
            OP_IN_A:   a_d   = btn;
            OP_MOV_AI: a_d   = imm;
            OP_MOV_BA: b_d   = a_q;
            OP_IN_B:   b_d   = btn;
            OP_MOV_BI: b_d   = imm;
            OP_OUT_B:  led_d = b_q;
            OP_OUT_IM: led_d = imm;
            OP_JNC:    if (!c_q) pc_d = imm;
            OP_JMP:    pc_d  = imm;
            default:   ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q   <= 4'd0;
            b_q   <= 4'd0;
            c_q   <= 1'b0;
            pc_q  <= 4'd0;
            led_q <= 4'd0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            pc_q  <= pc_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;
    assign pc  = pc_q;

endmodule

// File: tb/tb_cpu_ram.sv
// Directed bench for cpu_ram: small hand-assembled programs with hand-computed
// register, PC and LED values checked after each executed instruction.
module tb_cpu_ram;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] led;
    logic       write_req;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic [3:0] pc;

    int total = 0;
    int bad   = 0;

    cpu_ram dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .led       (led),
        .write_req (write_req),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [7:0] data);
        write_req = 1'b1;
        w_addr    = addr;
        w_data    = data;
        step(1);
        write_req = 1'b0;
    endtask

    // Fill the reachable 16 instruction slots with NOP (opcode 1000).
    task automatic clear_prog();
        for (int i = 0; i < 16; i++) load(8'(i), 8'h80);
    endtask

    task automatic check_regs(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                              input logic ec);
        check({tag, ".a"}, {4'd0, dut.a_q}, {4'd0, ea});
        check({tag, ".b"}, {4'd0, dut.b_q}, {4'd0, eb});
        check({tag, ".c"}, {7'd0, dut.c_q}, {7'd0, ec});
    endtask

    initial begin
        reset     = 1'b0;
        btn       = 4'h0;
        write_req = 1'b0;
        w_addr    = 8'h00;
        w_data    = 8'h00;

        // Reset state
        step(2);
        check("rst.led", {4'd0, led}, 8'h00);
        check("rst.pc", {4'd0, pc}, 8'h00);
        check_regs("rst", 4'h0, 4'h0, 1'b0);

        // OUT 5 then JMP 1 forever; program written while held in reset
        clear_prog();
        load(8'h00, 8'hB5);
        load(8'h01, 8'hF1);
        check("hold.pc", {4'd0, pc}, 8'h00);
        reset = 1'b1;
        step(1);
        check("out5.led", {4'd0, led}, 8'h05);
        check("out5.pc", {4'd0, pc}, 8'h01);
        step(1);
        check("jmp1.pc", {4'd0, pc}, 8'h01);
        step(1);
        check("jmp1b.pc", {4'd0, pc}, 8'h01);
        check("jmp1b.led", {4'd0, led}, 8'h05);

        // Write to the address being fetched: old JMP 1 executes, then new OUT C
        write_req = 1'b1;
        w_addr    = 8'h01;
        w_data    = 8'hBC;
        step(1);
        write_req = 1'b0;
        check("rw.pc", {4'd0, pc}, 8'h01);
        check("rw.led", {4'd0, led}, 8'h05);
        step(1);
        check("rw2.led", {4'd0, led}, 8'h0C);
        check("rw2.pc", {4'd0, pc}, 8'h02);

        // MOV A,E; ADD A,3; MOV B,A; OUT B
        reset = 1'b0;
        clear_prog();
        load(8'h00, 8'h3E);
        load(8'h01, 8'h03);
        load(8'h02, 8'h40);
        load(8'h03, 8'h90);
        load(8'h04, 8'hF4);
        reset = 1'b1;
        step(1);
        check_regs("mov_ai", 4'hE, 4'h0, 1'b0);
        step(1);
        check_regs("add_ovf", 4'h1, 4'h0, 1'b1);
        step(1);
        check_regs("mov_ba", 4'h1, 4'h1, 1'b0);
        step(1);
        check("out_b.led", {4'd0, led}, 8'h01);
        step(2);
        check("self_jmp.pc", {4'd0, pc}, 8'h04);

        // ADD A,1; JNC 0; OUT F; JMP 3 -> 16 increments until carry
        reset = 1'b0;
        clear_prog();
        load(8'h00, 8'h01);
        load(8'h01, 8'hE0);
        load(8'h02, 8'hBF);
        load(8'h03, 8'hF3);
        reset = 1'b1;
        step(2);
        check_regs("cnt1", 4'h1, 4'h0, 1'b0);
        check("cnt1.pc", {4'd0, pc}, 8'h00);
        step(28);
        check_regs("cnt15", 4'hF, 4'h0, 1'b0);
        check("cnt15.led", {4'd0, led}, 8'h00);
        step(1);
        check_regs("cnt_carry", 4'h0, 4'h0, 1'b1);
        step(1);
        check("jnc_fall.pc", {4'd0, pc}, 8'h02);
        check_regs("jnc_fall", 4'h0, 4'h0, 1'b0);
        step(1);
        check("loop_out.led", {4'd0, led}, 8'h0F);
        step(1);
        check("loop_end.pc", {4'd0, pc}, 8'h03);

        // IN A; MOV B,A; OUT B with btn=A
        reset = 1'b0;
        clear_prog();
        load(8'h00, 8'h20);
        load(8'h01, 8'h40);
        load(8'h02, 8'h90);
        load(8'h03, 8'hF3);
        btn   = 4'hA;
        reset = 1'b1;
        step(3);
        check("in_a.led", {4'd0, led}, 8'h0A);
        check_regs("in_a", 4'hA, 4'hA, 1'b0);

        // Mid-run reset clears state but keeps memory
        reset = 1'b0;
        step(1);
        check("mid_rst.led", {4'd0, led}, 8'h00);
        check("mid_rst.pc", {4'd0, pc}, 8'h00);
        check_regs("mid_rst", 4'h0, 4'h0, 1'b0);
        reset = 1'b1;
        step(3);
        check("mem_kept.led", {4'd0, led}, 8'h0A);

        // IN B; ADD B,9; MOV A,B with btn=9
        reset = 1'b0;
        clear_prog();
        load(8'h00, 8'h66);
        load(8'h01, 8'h59);
        load(8'h02, 8'h14);
        load(8'h03, 8'hF3);
        btn   = 4'h9;
        reset = 1'b1;
        step(1);
        check_regs("in_b", 4'h0, 4'h9, 1'b0);
        step(1);
        check_regs("add_b", 4'h0, 4'h2, 1'b1);
        step(1);
        check_regs("mov_ab", 4'h2, 4'h2, 1'b0);

        // Sixteen NOPs: PC wraps, LED untouched
        reset = 1'b0;
        clear_prog();
        reset = 1'b1;
        step(15);
        check("nop15.pc", {4'd0, pc}, 8'h0F);
        step(1);
        check("nop_wrap.pc", {4'd0, pc}, 8'h00);
        check("nop_wrap.led", {4'd0, led}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
